// File: rtl/muxn_rr_if.sv
// Handshake bundle for the N-channel registered mux: per-channel producer side,
// single consumer side, plus the selection controls.
interface muxn_rr_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
);
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_src;

  // master: the environment driving producers/consumer; slave: the mux itself
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src
  );
endinterface

// File: rtl/muxn_rr.sv
// N-channel W-bit mux with a one-deep registered output, manual or round-robin
// selection, and valid/ready handshakes on every input and on the output.
module muxn_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = 2
) (
  input  logic       clk,
  input  logic       rst,
  muxn_rr_if.slave   bus
);

  logic [SW-1:0] rr_ptr;
  logic          vld_p1;
  logic [W-1:0]  data_p1;
  logic [SW-1:0] src_p1;

  logic          advance;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  grant_data;
  logic [N-1:0]  ready_vec;
  logic          xfer;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] idx);
    if (int'(idx) >= N - 1) return '0;
    return idx + 1'b1;
  endfunction

  assign advance = ~vld_p1 | bus.out_ready;

  // ---- stage p0: combinational grant and input handshake ----
  always_comb begin : grant_sel
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!bus.mode) begin
      for (int i = 0; i < N; i++) begin
        if (int'(bus.sel) == i && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(i);
        end
      end
    end else begin
      // Scan from the farthest offset down so the one nearest rr_ptr wins last.
      for (int k = N - 1; k >= 0; k--) begin
        cand = int'(rr_ptr) + k;
        if (cand >= N) cand = cand - N;
        if (bus.in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = SW'(cand);
        end
      end
    end
  end

  always_comb begin : data_sel
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) grant_data = bus.in_data[i*W +: W];
    end
  end

  assign xfer = grant_vld & advance & ~rst;

  always_comb begin : ready_gen
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (xfer && grant_idx == SW'(i)) ready_vec[i] = 1'b1;
    end
  end

  assign bus.in_ready = ready_vec;

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (advance) begin
        if (grant_vld) begin
          vld_p1  <= 1'b1;
          data_p1 <= grant_data;
          src_p1  <= grant_idx;
        end else begin
          vld_p1  <= 1'b0;
        end
      end
      if (bus.mode && xfer) rr_ptr <= wrap_inc(grant_idx);
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;

endmodule

// File: tb/tb_muxn_rr.sv
// Randomized and directed bench for muxn_rr against a queue-based reference model.
module tb_muxn_rr;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  muxn_rr_if #(.N(N), .W(W), .SW(SW)) bus ();
  muxn_rr #(.N(N), .W(W), .SW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  muxn_rr_if #(.N(3), .W(W), .SW(2)) bus3 ();
  muxn_rr #(.N(3), .W(W), .SW(2)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  int n_vec = 0;
  int n_err = 0;

  // model state (what the output register should hold, and the rr pointer)
  bit         m_vld;
  logic [7:0] m_data;
  int         m_src;
  int         m_ptr;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant rule: manual picks sel if valid; round-robin takes the first valid
  // index at or after ptr, otherwise the lowest valid index.
  function automatic int model_grant(bit mode, int sel, logic [N-1:0] valid, int ptr);
    int vq[$];
    for (int i = 0; i < N; i++) if (valid[i]) vq.push_back(i);
    if (!mode) begin
      if (sel < N) begin
        if (valid[sel]) return sel;
      end
      return -1;
    end
    foreach (vq[j]) if (vq[j] >= ptr) return vq[j];
    if (vq.size() > 0) return vq[0];
    return -1;
  endfunction

  task automatic cycle();
    int         g;
    bit         adv;
    logic [N-1:0] er;
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(m_vld));
    check("out_data",  32'(bus.out_data),  32'(m_data));
    check("out_src",   32'(bus.out_src),   32'(m_src));
    adv = !m_vld || bus.out_ready;
    g   = model_grant(bus.mode, int'(bus.sel), bus.in_valid, m_ptr);
    er  = '0;
    if (!rst && adv && g >= 0) er[g] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (adv) begin
      if (g >= 0) begin
        m_vld  = 1;
        m_data = bus.in_data[g*W +: W];
        m_src  = g;
        if (bus.mode) m_ptr = (g + 1) % N;
      end else begin
        m_vld = 0;
      end
    end
    #1;
  endtask

  task automatic set_in(bit mode, int sel, logic [N-1:0] valid, bit ordy);
    bus.mode      = mode;
    bus.sel       = SW'(sel);
    bus.in_valid  = valid;
    bus.out_ready = ordy;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 8'hA0 + 8'(i);
  endtask

  initial begin
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; rst3 = 1'b1;
    m_vld = 0; m_data = '0; m_src = 0; m_ptr = 0;
    set_in(0, 0, '0, 1'b1);
    load_ramp();
    bus3.mode = 0; bus3.sel = '0; bus3.in_valid = '0; bus3.out_ready = 1'b1;
    bus3.in_data = {8'h33, 8'h22, 8'h11};
    #1;
    cycle();
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data",  32'(bus.out_data),  0);
    check("rst_src",   32'(bus.out_src),   0);

    // manual select
    set_in(0, 1, 4'hF, 1'b1);
    cycle();
    check("man_data1", 32'(bus.out_data), 32'h A1);
    check("man_src1",  32'(bus.out_src),  1);
    set_in(0, 0, 4'hF, 1'b1);
    cycle();
    check("man_data0", 32'(bus.out_data), 32'h A0);
    check("man_src0",  32'(bus.out_src),  0);

    // round-robin fairness from a fresh pointer
    rst = 1'b1; cycle(); rst = 1'b0;
    set_in(1, 0, 4'hF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr_src",  32'(bus.out_src),  32'(exp_seq[k]));
      check("rr_data", 32'(bus.out_data), 32'(8'hA0 + 8'(exp_seq[k])));
    end

    // reset mid-stream with the pointer at 2
    rst = 1'b1; cycle(); rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_data",  32'(bus.out_data),  0);
    check("mid_rst_src",   32'(bus.out_src),   0);
    cycle();
    check("post_rst_src", 32'(bus.out_src), 0);

    // sparse round-robin with wrap: move pointer to 2, then only ch3/ch1 valid
    cycle();
    set_in(1, 0, 4'b1010, 1'b1);
    cycle(); check("sparse_a", 32'(bus.out_src), 3);
    cycle(); check("sparse_b", 32'(bus.out_src), 1);
    cycle(); check("sparse_c", 32'(bus.out_src), 3);

    // backpressure holds the registered word
    bus.in_data[2*W +: W] = 8'h55;
    set_in(0, 2, 4'hF, 1'b1);
    cycle();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_data",  32'(bus.out_data), 32'h55);
      check("bp_ready", 32'(bus.in_ready), 0);
    end
    set_in(0, 1, 4'hF, 1'b1);
    cycle();
    check("bp_release", 32'(bus.out_data), 32'h A1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.mode      = 1'($urandom_range(0, 1));
      bus.sel       = SW'($urandom_range(0, 3));
      bus.in_valid  = N'($urandom);
      bus.in_data   = (N*W)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;

    // three-channel instance: select index beyond the last channel
    rst3 = 1'b0;
    bus3.sel = 2'd0; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    check("n3_valid", 32'(bus3.out_valid), 1);
    check("n3_data",  32'(bus3.out_data),  32'h11);
    bus3.sel = 2'd3;
    #1;
    check("n3_oor_ready", 32'(bus3.in_ready), 0);
    @(posedge clk); #1;
    check("n3_oor_drain", 32'(bus3.out_valid), 0);
    check("n3_oor_hold",  32'(bus3.out_data),  32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
